// File: rtl/shift_unit.sv
// Multi-cycle shifter for the AC/MQ register pair: one bit position per clock,
// single or double-width shifts, driven by a start/busy/done handshake.
module shift_unit #(
    parameter int WIDTH = 40,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] mq_in,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] ac_out,
    output logic [WIDTH-1:0] mq_out,
    output logic             sh_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_ac;
    logic [WIDTH-1:0] r_mq;
    logic             r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_mode;

    logic [WIDTH-1:0] w_ac_nxt;
    logic [WIDTH-1:0] w_mq_nxt;
    logic             w_sh_nxt;
    logic             w_legal;

    // Modes 11x are reserved and complete immediately without shifting.
    assign w_legal = ~(mode[2] & mode[1]);

    always_comb begin
        w_ac_nxt = r_ac;
        w_mq_nxt = r_mq;
        w_sh_nxt = r_sh;
        case (r_mode)
            3'b000: begin
                w_ac_nxt = {1'b0, r_ac[WIDTH-1:1]};
                w_sh_nxt = r_ac[0];
            end
            3'b001: begin
                w_ac_nxt = {r_ac[WIDTH-2:0], 1'b0};
                w_sh_nxt = r_ac[WIDTH-1];
            end
            3'b010: begin
                w_ac_nxt = {r_ac[WIDTH-1], r_ac[WIDTH-1:1]};
                w_sh_nxt = r_ac[0];
            end
            3'b011: begin
                w_ac_nxt = {r_ac[0], r_ac[WIDTH-1:1]};
                w_sh_nxt = r_ac[0];
            end
            3'b100: begin
                w_ac_nxt = {1'b0, r_ac[WIDTH-1:1]};
                w_mq_nxt = {r_ac[0], r_mq[WIDTH-1:1]};
                w_sh_nxt = r_mq[0];
            end
            3'b101: begin
                w_ac_nxt = {r_ac[WIDTH-2:0], r_mq[WIDTH-1]};
                w_mq_nxt = {r_mq[WIDTH-2:0], 1'b0};
                w_sh_nxt = r_ac[WIDTH-1];
            end
            default: begin
            end
        endcase
    end

    // Load has priority over start; both are ignored outside IDLE.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_ac    <= '0;
            r_mq    <= '0;
            r_sh    <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_ac <= ac_in;
                        r_mq <= mq_in;
                    end else if (start) begin
                        if (w_legal && (amount != '0)) begin
                            r_state <= S_SHIFT;
                            r_cnt   <= amount;
                            r_mode  <= mode;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_ac  <= w_ac_nxt;
                    r_mq  <= w_mq_nxt;
                    r_sh  <= w_sh_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ac_out = r_ac;
    assign mq_out = r_mq;
    assign sh_out = r_sh;
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Directed self-checking bench for shift_unit at WIDTH=8 with hand-computed
// expected register contents, latencies and handshake behaviour.
module tb_shift_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 6;

    logic             clk;
    logic             rst_b;
    logic             load;
    logic [WIDTH-1:0] ac_in;
    logic [WIDTH-1:0] mq_in;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] ac_out;
    logic [WIDTH-1:0] mq_out;
    logic             sh_out;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    shift_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .load   (load),
        .ac_in  (ac_in),
        .mq_in  (mq_in),
        .start  (start),
        .mode   (mode),
        .amount (amount),
        .ac_out (ac_out),
        .mq_out (mq_out),
        .sh_out (sh_out),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic loadRegs(input logic [WIDTH-1:0] ac, input logic [WIDTH-1:0] mq);
        load  = 1'b1;
        ac_in = ac;
        mq_in = mq;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Issues start, then counts cycles (from the first cycle after the start
    // edge) until done is seen, tallying busy cycles along the way.
    task automatic applyStimulus(input string tag, input logic [2:0] m,
                                 input logic [CNT_W-1:0] a, input int expCycles);
        int cyc;
        int busyCnt;
        busyCnt = 0;
        start   = 1'b1;
        mode    = m;
        amount  = a;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc <= 100; cyc++) begin
            if (busy) busyCnt++;
            if (done) break;
            @(negedge clk);
        end
        checkOutput({tag, " done cycle"}, cyc, expCycles);
        checkOutput({tag, " busy cycles"}, busyCnt, expCycles);
        @(negedge clk);
        checkOutput({tag, " done width"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " idle after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seenDone;
        rst_b  = 1'b0;
        load   = 1'b0;
        start  = 1'b0;
        mode   = 3'b000;
        amount = '0;
        ac_in  = '0;
        mq_in  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset ac", ac_out, 0);
        checkOutput("reset mq", mq_out, 0);
        checkOutput("reset sh", sh_out, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        rst_b = 1'b1;
        @(negedge clk);

        loadRegs(8'hA5, 8'h3C);
        checkOutput("load ac", ac_out, 8'hA5);
        checkOutput("load mq", mq_out, 8'h3C);
        checkOutput("load busy", busy, 0);

        loadRegs(8'h96, 8'h3C);
        applyStimulus("asr3", 3'b010, 6'd3, 4);
        checkOutput("asr3 ac", ac_out, 8'hF2);
        checkOutput("asr3 sh", sh_out, 1);
        checkOutput("asr3 mq", mq_out, 8'h3C);

        loadRegs(8'h81, 8'h5A);
        applyStimulus("ror9", 3'b011, 6'd9, 10);
        checkOutput("ror9 ac", ac_out, 8'hC0);
        checkOutput("ror9 mq", mq_out, 8'h5A);

        loadRegs(8'h01, 8'h00);
        applyStimulus("dsr2", 3'b100, 6'd2, 3);
        checkOutput("dsr2 ac", ac_out, 8'h00);
        checkOutput("dsr2 mq", mq_out, 8'h40);
        checkOutput("dsr2 sh", sh_out, 0);
        applyStimulus("dsl2", 3'b101, 6'd2, 3);
        checkOutput("dsl2 ac", ac_out, 8'h01);
        checkOutput("dsl2 mq", mq_out, 8'h00);

        loadRegs(8'hB4, 8'h00);
        applyStimulus("lsr10", 3'b000, 6'd10, 11);
        checkOutput("lsr10 ac", ac_out, 8'h00);
        loadRegs(8'h81, 8'h00);
        applyStimulus("lsl1", 3'b001, 6'd1, 2);
        checkOutput("lsl1 ac", ac_out, 8'h02);
        checkOutput("lsl1 sh", sh_out, 1);

        applyStimulus("amt0", 3'b001, 6'd0, 1);
        checkOutput("amt0 ac", ac_out, 8'h02);
        checkOutput("amt0 sh", sh_out, 1);
        applyStimulus("rsvd", 3'b110, 6'd5, 1);
        checkOutput("rsvd ac", ac_out, 8'h02);
        checkOutput("rsvd mq", mq_out, 8'h00);

        load  = 1'b1;
        start = 1'b1;
        ac_in = 8'h77;
        mq_in = 8'h11;
        mode  = 3'b000;
        amount = 6'd2;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        checkOutput("ldst busy", busy, 0);
        checkOutput("ldst ac", ac_out, 8'h77);
        @(negedge clk);
        checkOutput("ldst still idle", busy, 0);
        checkOutput("ldst ac held", ac_out, 8'h77);

        // Load/start during SHIFT must not disturb the running operation.
        loadRegs(8'h96, 8'h3C);
        start  = 1'b1;
        mode   = 3'b010;
        amount = 6'd3;
        @(negedge clk);
        load   = 1'b1;
        start  = 1'b1;
        ac_in  = 8'h00;
        mq_in  = 8'hFF;
        mode   = 3'b001;
        amount = 6'd7;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("busy ign ac", ac_out, 8'hF2);
        checkOutput("busy ign mq", mq_out, 8'h3C);
        checkOutput("busy ign idle", busy, 0);

        loadRegs(8'h5A, 8'hC3);
        start  = 1'b1;
        mode   = 3'b011;
        amount = 6'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        checkOutput("abort ac", ac_out, 0);
        checkOutput("abort mq", mq_out, 0);
        checkOutput("abort sh", sh_out, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        @(negedge clk);
        rst_b = 1'b1;
        seenDone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seenDone = 1;
        end
        checkOutput("abort no done", seenDone, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
